// File: rtl/alu_reservation_station.sv
// alu_reservation_station: buffers renamed ALU/branch ops until both operands
// resolve, then issues the lowest ready slot to a single-cycle ALU each cycle.
module alu_reservation_station #(
    parameter int ENTRIES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [4:0]  op_in,
    input  logic [31:0] value1_in,
    input  logic [31:0] value2_in,
    input  logic [2:0]  query1_in,
    input  logic [2:0]  query2_in,
    input  logic [2:0]  target_in,
    input  logic [2:0]  mem_num,
    input  logic [31:0] mem_value,
    output logic        rs_full,
    output logic [2:0]  alu_num,
    output logic [31:0] alu_value,
    output logic        drop
);
    localparam int IW = $clog2(ENTRIES);
    localparam int CW = $clog2(ENTRIES + 1);

    localparam logic [4:0] OP_ADD  = 5'b00000, OP_AND  = 5'b00001, OP_OR   = 5'b00010;
    localparam logic [4:0] OP_SLL  = 5'b00011, OP_SRL  = 5'b00100, OP_SLT  = 5'b00101;
    localparam logic [4:0] OP_SLTU = 5'b00110, OP_SRA  = 5'b00111, OP_SUB  = 5'b01000;
    localparam logic [4:0] OP_XOR  = 5'b01001, OP_BEQ  = 5'b01010, OP_BGE  = 5'b01011;
    localparam logic [4:0] OP_BNE  = 5'b01100, OP_BGEU = 5'b01101, OP_JALR = 5'b10001;
    localparam logic [4:0] OP_BLT  = 5'b11010, OP_BLTU = 5'b11011;

    typedef struct packed {
        logic        busy;
        logic [4:0]  op;
        logic [31:0] v1;
        logic [2:0]  q1;
        logic [31:0] v2;
        logic [2:0]  q2;
        logic [2:0]  tag;
    } entry_t;

    entry_t        entry_q [ENTRIES];
    entry_t        entry_d [ENTRIES];
    logic [2:0]    alu_num_q, alu_num_d;
    logic [31:0]   alu_value_q, alu_value_d;
    logic          drop_q, drop_d;

    logic          sel_found, free_found;
    logic [IW-1:0] sel_idx, free_idx;
    logic [CW-1:0] free_cnt;

    function automatic logic op_legal(input logic [4:0] op);
        case (op)
            OP_ADD, OP_AND, OP_OR, OP_SLL, OP_SRL, OP_SLT, OP_SLTU, OP_SRA, OP_SUB,
            OP_XOR, OP_BEQ, OP_BGE, OP_BNE, OP_BGEU, OP_JALR, OP_BLT, OP_BLTU:
                op_legal = 1'b1;
            default: op_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] alu_exec(input logic [4:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
        alu_exec = '0;
        case (op)
            OP_ADD:  alu_exec = a + b;
            OP_SUB:  alu_exec = a - b;
            OP_AND:  alu_exec = a & b;
            OP_OR:   alu_exec = a | b;
            OP_XOR:  alu_exec = a ^ b;
            OP_SLL:  alu_exec = a << b[4:0];
            OP_SRL:  alu_exec = a >> b[4:0];
            OP_SRA:  alu_exec = $signed(a) >>> b[4:0];
            OP_SLT:  alu_exec = {31'd0, $signed(a) < $signed(b)};
            OP_SLTU: alu_exec = {31'd0, a < b};
            OP_BEQ:  alu_exec = {31'd0, a == b};
            OP_BNE:  alu_exec = {31'd0, a != b};
            OP_BGE:  alu_exec = {31'd0, $signed(a) >= $signed(b)};
            OP_BLT:  alu_exec = {31'd0, $signed(a) < $signed(b)};
            OP_BGEU: alu_exec = {31'd0, a >= b};
            OP_BLTU: alu_exec = {31'd0, a < b};
            OP_JALR: alu_exec = (a + b) & ~32'd1;
            default: alu_exec = '0;
        endcase
    endfunction

    // A matching load broadcast takes priority over the ALU's own broadcast.
    function automatic logic [34:0] snoop(input logic [2:0] q, input logic [31:0] v,
                                          input logic [2:0] a_num, input logic [31:0] a_val,
                                          input logic [2:0] m_num, input logic [31:0] m_val);
        if (q != 3'd0 && q == m_num)      snoop = {3'd0, m_val};
        else if (q != 3'd0 && q == a_num) snoop = {3'd0, a_val};
        else                              snoop = {q, v};
    endfunction

    always_comb begin
        sel_found  = 1'b0;
        sel_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        free_cnt   = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (!sel_found && entry_q[i].busy && entry_q[i].q1 == 3'd0 && entry_q[i].q2 == 3'd0) begin
                sel_found = 1'b1;
                sel_idx   = IW'(i);
            end
            if (!entry_q[i].busy) begin
                free_cnt = free_cnt + CW'(1);
                if (!free_found) begin
                    free_found = 1'b1;
                    free_idx   = IW'(i);
                end
            end
        end
    end

    assign rs_full = (free_cnt <= CW'(1));

    // Selection and allocation both look only at pre-edge state, so a slot
    // freed by this edge's issue cannot be refilled until the next edge.
    always_comb begin
        alu_num_d   = 3'd0;
        alu_value_d = alu_value_q;
        drop_d      = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            entry_d[i] = entry_q[i];
            if (entry_q[i].busy) begin
                {entry_d[i].q1, entry_d[i].v1} = snoop(entry_q[i].q1, entry_q[i].v1,
                                                       alu_num_q, alu_value_q, mem_num, mem_value);
                {entry_d[i].q2, entry_d[i].v2} = snoop(entry_q[i].q2, entry_q[i].v2,
                                                       alu_num_q, alu_value_q, mem_num, mem_value);
            end
        end
        if (sel_found) begin
            alu_num_d             = entry_q[sel_idx].tag;
            alu_value_d           = alu_exec(entry_q[sel_idx].op, entry_q[sel_idx].v1, entry_q[sel_idx].v2);
            entry_d[sel_idx].busy = 1'b0;
        end
        if (op_legal(op_in)) begin
            if (free_found) begin
                entry_d[free_idx].busy = 1'b1;
                entry_d[free_idx].op   = op_in;
                entry_d[free_idx].tag  = target_in;
                {entry_d[free_idx].q1, entry_d[free_idx].v1} = snoop(query1_in, value1_in,
                                                               alu_num_q, alu_value_q, mem_num, mem_value);
                {entry_d[free_idx].q2, entry_d[free_idx].v2} = snoop(query2_in, value2_in,
                                                               alu_num_q, alu_value_q, mem_num, mem_value);
            end else begin
                drop_d = 1'b1;
            end
        end
        if (!rst || flush) begin
            for (int i = 0; i < ENTRIES; i++) entry_d[i].busy = 1'b0;
            alu_num_d   = 3'd0;
            alu_value_d = 32'd0;
            drop_d      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < ENTRIES; i++) entry_q[i] <= entry_d[i];
        alu_num_q   <= alu_num_d;
        alu_value_q <= alu_value_d;
        drop_q      <= drop_d;
    end

    assign alu_num   = alu_num_q;
    assign alu_value = alu_value_q;
    assign drop      = drop_q;
endmodule

// File: tb/tb_alu_reservation_station.sv
// tb_alu_reservation_station: directed scenarios plus randomized traffic, with a
// slot-level behavioural model of the station predicting every output.
module tb_alu_reservation_station;
    logic        clk = 1'b0;
    logic        rst, flush;
    logic [4:0]  op_in;
    logic [31:0] value1_in, value2_in, mem_value;
    logic [2:0]  query1_in, query2_in, target_in, mem_num;
    logic        rs_full, drop;
    logic [2:0]  alu_num;
    logic [31:0] alu_value;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    alu_reservation_station #(.ENTRIES(4)) dut (
        .clk(clk), .rst(rst), .flush(flush), .op_in(op_in),
        .value1_in(value1_in), .value2_in(value2_in),
        .query1_in(query1_in), .query2_in(query2_in), .target_in(target_in),
        .mem_num(mem_num), .mem_value(mem_value),
        .rs_full(rs_full), .alu_num(alu_num), .alu_value(alu_value), .drop(drop)
    );

    typedef struct {
        bit          busy;
        logic [4:0]  op;
        logic [31:0] v1, v2;
        logic [2:0]  q1, q2, tag;
    } slot_t;

    slot_t       m [4];
    logic [2:0]  m_num = 3'd0;
    logic [31:0] m_val = 32'd0;
    logic        m_drop = 1'b0;

    logic [4:0] legal_ops [17] = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101,
                                   5'b00110, 5'b00111, 5'b01000, 5'b01001, 5'b01010, 5'b01011,
                                   5'b01100, 5'b01101, 5'b10001, 5'b11010, 5'b11011};

    function automatic bit is_legal(logic [4:0] op);
        foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_alu(logic [4:0] op, logic [31:0] a, logic [31:0] b);
        int sa = a;
        int sb = b;
        int unsigned sh = b % 32;
        case (op)
            5'b00000: return a + b;
            5'b01000: return a - b;
            5'b00001: return a & b;
            5'b00010: return a | b;
            5'b01001: return a ^ b;
            5'b00011: return a << sh;
            5'b00100: return a >> sh;
            5'b00111: return 32'(sa >>> sh);
            5'b00101, 5'b11010: return (sa < sb) ? 32'd1 : 32'd0;
            5'b00110, 5'b11011: return (a < b) ? 32'd1 : 32'd0;
            5'b01010: return (a == b) ? 32'd1 : 32'd0;
            5'b01100: return (a != b) ? 32'd1 : 32'd0;
            5'b01011: return (sa >= sb) ? 32'd1 : 32'd0;
            5'b01101: return (a >= b) ? 32'd1 : 32'd0;
            5'b10001: return (a + b) & 32'hFFFF_FFFE;
            default:  return 32'd0;
        endcase
    endfunction

    function automatic logic [34:0] resolve(logic [2:0] q, logic [31:0] v);
        if (q != 0 && q == mem_num) return {3'd0, mem_value};
        if (q != 0 && q == m_num)   return {3'd0, m_val};
        return {q, v};
    endfunction

    function automatic logic exp_full();
        int n = 0;
        foreach (m[i]) if (m[i].busy) n++;
        return (4 - n) <= 1;
    endfunction

    // Advances the model by one clock edge using the inputs held across that edge.
    task automatic model_edge();
        slot_t       nxt [4];
        int          pick = -1;
        int          hole = -1;
        logic [34:0] r;
        logic [2:0]  new_num;
        logic [31:0] new_val;
        if (!rst || flush) begin
            foreach (m[i]) m[i].busy = 1'b0;
            m_num = 3'd0; m_val = 32'd0; m_drop = 1'b0;
        end else begin
            foreach (m[i]) begin
                if (pick < 0 && m[i].busy && m[i].q1 == 0 && m[i].q2 == 0) pick = i;
                if (hole < 0 && !m[i].busy) hole = i;
            end
            nxt = m;
            foreach (nxt[i]) if (nxt[i].busy) begin
                r = resolve(nxt[i].q1, nxt[i].v1); nxt[i].q1 = r[34:32]; nxt[i].v1 = r[31:0];
                r = resolve(nxt[i].q2, nxt[i].v2); nxt[i].q2 = r[34:32]; nxt[i].v2 = r[31:0];
            end
            new_num = 3'd0;
            new_val = m_val;
            if (pick >= 0) begin
                new_num = m[pick].tag;
                new_val = ref_alu(m[pick].op, m[pick].v1, m[pick].v2);
                nxt[pick].busy = 1'b0;
            end
            m_drop = 1'b0;
            if (is_legal(op_in)) begin
                if (hole >= 0) begin
                    nxt[hole].busy = 1'b1;
                    nxt[hole].op   = op_in;
                    nxt[hole].tag  = target_in;
                    r = resolve(query1_in, value1_in); nxt[hole].q1 = r[34:32]; nxt[hole].v1 = r[31:0];
                    r = resolve(query2_in, value2_in); nxt[hole].q2 = r[34:32]; nxt[hole].v2 = r[31:0];
                end else begin
                    m_drop = 1'b1;
                end
            end
            m = nxt;
            m_num = new_num;
            m_val = new_val;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        rst = 1'b1; flush = 1'b0; op_in = 5'h1f;
        value1_in = '0; value2_in = '0; query1_in = '0; query2_in = '0; target_in = 3'd1;
        mem_num = '0; mem_value = '0;
    endtask

    task automatic issue(logic [4:0] op, logic [31:0] a, logic [31:0] b,
                         logic [2:0] qa, logic [2:0] qb, logic [2:0] tg);
        op_in = op; value1_in = a; value2_in = b; query1_in = qa; query2_in = qb; target_in = tg;
    endtask

    task automatic test_reset();
        idle(); rst = 1'b0; tick(); tick();
        if (alu_num !== 3'd0) begin miscompares++; $display("[TB] FAIL reset_num: got %0d want 0", alu_num); end
        vectors++;
        if (alu_value !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_value: got %h want 0", alu_value); end
        vectors++;
        if (drop !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_drop: got %b want 0", drop); end
        vectors++;
        if (rs_full !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_full: got %b want 0", rs_full); end
        vectors++;
        idle(); issue(5'b00000, 32'd5, 32'd7, 3'd0, 3'd0, 3'd3); tick(); idle();
        if (alu_num !== 3'd0) begin miscompares++; $display("[TB] FAIL add_latency: got %0d want 0", alu_num); end
        vectors++;
        tick();
        if (alu_num !== 3'd3 || alu_value !== 32'd12) begin
            miscompares++; $display("[TB] FAIL add_result: got %0d/%0d want 3/12", alu_num, alu_value);
        end
        vectors++;
        tick();
        if (alu_num !== 3'd0 || alu_value !== 32'd12) begin
            miscompares++; $display("[TB] FAIL add_after: got %0d/%0d want 0/12", alu_num, alu_value);
        end
        vectors++;
    endtask

    task automatic test_dependency();
        idle(); issue(5'b00000, 32'd5, 32'd7, 3'd0, 3'd0, 3'd3); tick();
        issue(5'b01000, 32'd0, 32'd1, 3'd3, 3'd0, 3'd2); tick(); idle();
        if (alu_num !== 3'd3 || alu_value !== 32'd12) begin
            miscompares++; $display("[TB] FAIL dep_producer: got %0d/%0d want 3/12", alu_num, alu_value);
        end
        vectors++;
        tick();
        if (alu_num !== 3'd0) begin miscompares++; $display("[TB] FAIL dep_wake_gap: got %0d want 0", alu_num); end
        vectors++;
        tick();
        if (alu_num !== 3'd2 || alu_value !== 32'd11) begin
            miscompares++; $display("[TB] FAIL dep_consumer: got %0d/%0d want 2/11", alu_num, alu_value);
        end
        vectors++;
    endtask

    task automatic test_forwarding();
        idle(); issue(5'b00110, 32'd1, 32'd0, 3'd0, 3'd4, 3'd1);
        mem_num = 3'd4; mem_value = 32'hFFFF_FFFF; tick(); idle(); tick();
        if (alu_num !== 3'd1 || alu_value !== 32'd1) begin
            miscompares++; $display("[TB] FAIL fwd_sltu: got %0d/%0d want 1/1", alu_num, alu_value);
        end
        vectors++;
        issue(5'b00101, 32'd1, 32'd0, 3'd0, 3'd4, 3'd2);
        mem_num = 3'd4; mem_value = 32'hFFFF_FFFF; tick(); idle(); tick();
        if (alu_num !== 3'd2 || alu_value !== 32'd0) begin
            miscompares++; $display("[TB] FAIL fwd_slt: got %0d/%0d want 2/0", alu_num, alu_value);
        end
        vectors++;
        issue(5'b00000, 32'd20, 32'd22, 3'd0, 3'd0, 3'd3); tick(); idle(); tick();
        issue(5'b01000, 32'd0, 32'd2, 3'd3, 3'd0, 3'd4); tick(); idle(); tick();
        if (alu_num !== 3'd4 || alu_value !== 32'd40) begin
            miscompares++; $display("[TB] FAIL fwd_alu_bus: got %0d/%0d want 4/40", alu_num, alu_value);
        end
        vectors++;
    endtask

    task automatic test_back_to_back();
        idle(); issue(5'b01011, 32'hFFFF_FFFF, 32'd0, 3'd0, 3'd0, 3'd5); tick();
        issue(5'b10001, 32'h1001, 32'h10, 3'd0, 3'd0, 3'd6); tick(); idle();
        if (alu_num !== 3'd5 || alu_value !== 32'd0) begin
            miscompares++; $display("[TB] FAIL bge: got %0d/%0h want 5/0", alu_num, alu_value);
        end
        vectors++;
        tick();
        if (alu_num !== 3'd6 || alu_value !== 32'h1010) begin
            miscompares++; $display("[TB] FAIL jalr: got %0d/%0h want 6/1010", alu_num, alu_value);
        end
        vectors++;
    endtask

    task automatic test_fill();
        idle();
        for (int i = 0; i < 4; i++) begin
            issue(5'b00000, 32'd0, 32'(i + 1), 3'd7, 3'd0, 3'(i + 1)); tick();
            if (rs_full !== (i >= 2)) begin
                miscompares++; $display("[TB] FAIL fill_full_%0d: got %b want %b", i, rs_full, i >= 2);
            end
            vectors++;
        end
        issue(5'b00000, 32'd0, 32'd9, 3'd7, 3'd0, 3'd5); tick(); idle();
        if (drop !== 1'b1) begin miscompares++; $display("[TB] FAIL fill_drop: got %b want 1", drop); end
        vectors++;
        tick();
        if (drop !== 1'b0) begin miscompares++; $display("[TB] FAIL fill_drop_pulse: got %b want 0", drop); end
        vectors++;
        mem_num = 3'd7; mem_value = 32'd100; tick(); idle();
        if (alu_num !== 3'd0) begin miscompares++; $display("[TB] FAIL fill_wake: got %0d want 0", alu_num); end
        vectors++;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (alu_num !== 3'(i + 1) || alu_value !== 32'(101 + i)) begin
                miscompares++;
                $display("[TB] FAIL fill_order_%0d: got %0d/%0d want %0d/%0d", i, alu_num, alu_value, i + 1, 101 + i);
            end
            vectors++;
        end
        if (rs_full !== 1'b0) begin miscompares++; $display("[TB] FAIL fill_drained: got %b want 0", rs_full); end
        vectors++;
    endtask

    task automatic test_flush(bit use_rst);
        idle();
        for (int i = 0; i < 3; i++) begin
            issue(5'b00010, 32'(i), 32'd8, 3'd6, 3'd0, 3'(i + 1)); tick();
        end
        idle(); mem_num = 3'd6; mem_value = 32'h30; tick(); idle();
        if (rs_full !== 1'b1) begin miscompares++; $display("[TB] FAIL clear_pre_full: got %b want 1", rs_full); end
        vectors++;
        if (use_rst) rst = 1'b0; else flush = 1'b1;
        tick(); idle();
        if (alu_num !== 3'd0 || alu_value !== 32'd0 || rs_full !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL clear_rst%0d: got num=%0d val=%0h full=%b want 0/0/0", use_rst, alu_num, alu_value, rs_full);
        end
        vectors++;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (alu_num !== 3'd0) begin
                miscompares++; $display("[TB] FAIL clear_quiet_rst%0d: got %0d want 0", use_rst, alu_num);
            end
            vectors++;
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 500; c++) begin
            rst   = ($urandom_range(0, 99) != 0);
            flush = ($urandom_range(0, 59) == 0);
            op_in = ($urandom_range(0, 9) < 7) ? legal_ops[$urandom_range(0, 16)] : 5'($urandom);
            value1_in = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 40)) - 32'd20 : $urandom;
            value2_in = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 40)) - 32'd20 : $urandom;
            query1_in = $urandom_range(0, 1) ? 3'd0 : 3'($urandom_range(1, 7));
            query2_in = $urandom_range(0, 1) ? 3'd0 : 3'($urandom_range(1, 7));
            target_in = 3'($urandom_range(1, 7));
            mem_num   = $urandom_range(0, 1) ? 3'd0 : 3'($urandom_range(1, 7));
            mem_value = $urandom;
            tick();
            if (alu_num !== m_num) begin
                miscompares++; $display("[TB] FAIL rand_num cycle %0d: got %0d want %0d", c, alu_num, m_num);
            end
            vectors++;
            if (alu_value !== m_val) begin
                miscompares++; $display("[TB] FAIL rand_value cycle %0d: got %h want %h", c, alu_value, m_val);
            end
            vectors++;
            if (drop !== m_drop) begin
                miscompares++; $display("[TB] FAIL rand_drop cycle %0d: got %b want %b", c, drop, m_drop);
            end
            vectors++;
            if (rs_full !== exp_full()) begin
                miscompares++; $display("[TB] FAIL rand_full cycle %0d: got %b want %b", c, rs_full, exp_full());
            end
            vectors++;
        end
    endtask

    initial begin
        foreach (m[i]) m[i] = '{busy: 1'b0, op: 5'd0, v1: 32'd0, v2: 32'd0, q1: 3'd0, q2: 3'd0, tag: 3'd0};
        idle();
        test_reset();
        test_dependency();
        test_forwarding();
        test_back_to_back();
        test_fill();
        test_flush(1'b0);
        test_flush(1'b1);
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
